// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS control path: state codes,
// opcodes, funct fields and ALU control encodings.
package mips_pkg;

   localparam logic [3:0] ST_FETCH  = 4'd0;
   localparam logic [3:0] ST_DECODE = 4'd1;
   localparam logic [3:0] ST_MEMADR = 4'd2;
   localparam logic [3:0] ST_MEMRD  = 4'd3;
   localparam logic [3:0] ST_MEMWB  = 4'd4;
   localparam logic [3:0] ST_MEMWR  = 4'd5;
   localparam logic [3:0] ST_EXEC   = 4'd6;
   localparam logic [3:0] ST_ALUWB  = 4'd7;
   localparam logic [3:0] ST_BEQ    = 4'd8;
   localparam logic [3:0] ST_ADDIEX = 4'd9;
   localparam logic [3:0] ST_ADDIWB = 4'd10;
   localparam logic [3:0] ST_JUMP   = 4'd11;

   typedef enum logic [3:0] {
      FETCH  = ST_FETCH,
      DECODE = ST_DECODE,
      MEMADR = ST_MEMADR,
      MEMRD  = ST_MEMRD,
      MEMWB  = ST_MEMWB,
      MEMWR  = ST_MEMWR,
      EXEC   = ST_EXEC,
      ALUWB  = ST_ALUWB,
      BEQ    = ST_BEQ,
      ADDIEX = ST_ADDIEX,
      ADDIWB = ST_ADDIWB,
      JUMP   = ST_JUMP
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALUOp class and the instruction funct field to an ALU opcode.
module alu_decoder
   import mips_pkg::*;
(
   input  logic [1:0] ALUOp,
   input  logic [5:0] Funct,
   output logic [2:0] ALUControl
);

   // Funct is only meaningful for R-type (ALUOp 10); unknown functs fall back to add.
   always_comb begin
      ALUControl = ALU_ADD;
      case (ALUOp)
         2'b01: ALUControl = ALU_SUB;
         2'b10: begin
            case (Funct)
               FN_ADD:  ALUControl = ALU_ADD;
               FN_SUB:  ALUControl = ALU_SUB;
               FN_AND:  ALUControl = ALU_AND;
               FN_OR:   ALUControl = ALU_OR;
               FN_SLT:  ALUControl = ALU_SLT;
               default: ALUControl = ALU_ADD;
            endcase
         end
         default: ALUControl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle MIPS datapath; write enables are
// gated off while reset is held so none can pulse during reset.
module multicycle_control
   import mips_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] Op,
   input  logic [5:0] Funct,
   input  logic       Zero,
   output logic       IorD,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUControl,
   output logic [1:0] PCSrc,
   output logic       PCEn,
   output logic [3:0] State
);

   state_t     r_state;
   state_t     w_next;
   logic       w_iord, w_memwrite, w_irwrite, w_regdst, w_memtoreg, w_regwrite;
   logic       w_alusrca, w_pcwrite, w_branch;
   logic [1:0] w_alusrcb, w_pcsrc, w_aluop;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= FETCH;
      else       r_state <= w_next;
   end

   // Next-state and per-state output decode.
   always_comb begin
      w_next     = FETCH;
      w_iord     = 1'b0;
      w_memwrite = 1'b0;
      w_irwrite  = 1'b0;
      w_regdst   = 1'b0;
      w_memtoreg = 1'b0;
      w_regwrite = 1'b0;
      w_alusrca  = 1'b0;
      w_pcwrite  = 1'b0;
      w_branch   = 1'b0;
      w_alusrcb  = 2'b00;
      w_pcsrc    = 2'b00;
      w_aluop    = 2'b00;
      case (r_state)
         FETCH: begin
            w_next    = DECODE;
            w_alusrcb = 2'b01;
            w_irwrite = 1'b1;
            w_pcwrite = 1'b1;
         end
         DECODE: begin
            w_alusrcb = 2'b11;
            case (Op)
               OP_LW, OP_SW: w_next = MEMADR;
               OP_RTYPE:     w_next = EXEC;
               OP_BEQ:       w_next = BEQ;
               OP_ADDI:      w_next = ADDIEX;
               OP_J:         w_next = JUMP;
               default:      w_next = FETCH;
            endcase
         end
         MEMADR: begin
            w_next    = (Op == OP_SW) ? MEMWR : MEMRD;
            w_alusrca = 1'b1;
            w_alusrcb = 2'b10;
         end
         MEMRD: begin
            w_next = MEMWB;
            w_iord = 1'b1;
         end
         MEMWB: begin
            w_memtoreg = 1'b1;
            w_regwrite = 1'b1;
         end
         MEMWR: begin
            w_iord     = 1'b1;
            w_memwrite = 1'b1;
         end
         EXEC: begin
            w_next    = ALUWB;
            w_alusrca = 1'b1;
            w_aluop   = 2'b10;
         end
         ALUWB: begin
            w_regdst   = 1'b1;
            w_regwrite = 1'b1;
         end
         BEQ: begin
            w_alusrca = 1'b1;
            w_aluop   = 2'b01;
            w_pcsrc   = 2'b01;
            w_branch  = 1'b1;
         end
         ADDIEX: begin
            w_next    = ADDIWB;
            w_alusrca = 1'b1;
            w_alusrcb = 2'b10;
         end
         ADDIWB: w_regwrite = 1'b1;
         JUMP: begin
            w_pcsrc   = 2'b10;
            w_pcwrite = 1'b1;
         end
         default: w_next = FETCH;
      endcase
   end

   alu_decoder u_alu_decoder (
      .ALUOp      (w_aluop),
      .Funct      (Funct),
      .ALUControl (ALUControl)
   );

   assign IorD     = w_iord;
   assign RegDst   = w_regdst;
   assign MemtoReg = w_memtoreg;
   assign ALUSrcA  = w_alusrca;
   assign ALUSrcB  = w_alusrcb;
   assign PCSrc    = w_pcsrc;
   assign State    = r_state;
   assign IRWrite  = w_irwrite  & ~reset;
   assign MemWrite = w_memwrite & ~reset;
   assign RegWrite = w_regwrite & ~reset;
   assign PCEn     = (w_pcwrite | (w_branch & Zero)) & ~reset;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench: an instruction-level model predicts the
// state walk and per-cycle control outputs for each opcode.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] Op, Funct;
   logic       Zero;
   logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn;
   logic [1:0] ALUSrcB, PCSrc;
   logic [2:0] ALUControl;
   logic [3:0] State;

   int n_chk  = 0;
   int n_fail = 0;

   multicycle_control dut (
      .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
      .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
      .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .PCSrc(PCSrc),
      .PCEn(PCEn), .State(State)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // State walk of one instruction, from FETCH up to its last cycle.
   function automatic void state_walk(input logic [5:0] op, output int seq[$]);
      seq = {0, 1};
      case (op)
         6'b100011: seq = {0, 1, 2, 3, 4};
         6'b101011: seq = {0, 1, 2, 5};
         6'b000000: seq = {0, 1, 6, 7};
         6'b000100: seq = {0, 1, 8};
         6'b001000: seq = {0, 1, 9, 10};
         6'b000010: seq = {0, 1, 11};
         default:   seq = {0, 1};
      endcase
   endfunction

   function automatic logic [2:0] rtype_alu(input logic [5:0] fn);
      case (fn)
         6'b100000: return 3'b010;
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   // Entered 1 time unit after the edge that put the DUT in FETCH.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn);
      int  seq[$];
      int  n;
      bit  is_lw, is_sw, is_r, is_beq, is_addi, is_j, last, writes;
      state_walk(op, seq);
      n       = seq.size();
      is_lw   = (op == 6'b100011);
      is_sw   = (op == 6'b101011);
      is_r    = (op == 6'b000000);
      is_beq  = (op == 6'b000100);
      is_addi = (op == 6'b001000);
      is_j    = (op == 6'b000010);
      writes  = is_lw | is_r | is_addi;
      Op      = op;
      Funct   = fn;
      for (int k = 0; k < n; k++) begin
         Zero = 1'($urandom_range(1, 0));
         last = (k == n - 1) && (k >= 2);
         @(negedge clk);
         check_val("State",     State,     seq[k]);
         check_val("IRWrite",   IRWrite,   k == 0);
         check_val("RegWrite",  RegWrite,  last && writes);
         check_val("MemWrite",  MemWrite,  last && is_sw);
         check_val("PCEn",      PCEn,      (k == 0) || (last && (is_j || (is_beq && Zero))));
         check_val("RegDst",    RegDst,    last && is_r);
         check_val("MemtoReg",  MemtoReg,  last && is_lw);
         check_val("IorD",      IorD,      (k == 3) && (is_lw || is_sw));
         check_val("ALUSrcA",   ALUSrcA,   (k == 2) && (is_lw || is_sw || is_r || is_beq || is_addi));
         check_val("ALUSrcB",   ALUSrcB,   (k == 0) ? 2'b01 : (k == 1) ? 2'b11 :
                                           ((k == 2) && (is_lw || is_sw || is_addi)) ? 2'b10 : 2'b00);
         check_val("PCSrc",     PCSrc,     (last && is_beq) ? 2'b01 : (last && is_j) ? 2'b10 : 2'b00);
         check_val("ALUControl", ALUControl, (k == 2 && is_r) ? rtype_alu(fn) :
                                             (k == 2 && is_beq) ? 3'b110 : 3'b010);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, ".State"},    State,    4'd0);
      check_val({tag, ".IRWrite"},  IRWrite,  1'b0);
      check_val({tag, ".PCEn"},     PCEn,     1'b0);
      check_val({tag, ".MemWrite"}, MemWrite, 1'b0);
      check_val({tag, ".RegWrite"}, RegWrite, 1'b0);
      check_val({tag, ".ALUSrcB"},  ALUSrcB,  2'b01);
      check_val({tag, ".ALUCtl"},   ALUControl, 3'b010);
   endtask

   logic [5:0] ops[8] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                          6'b001000, 6'b000010, 6'b111111, 6'b000001};
   logic [5:0] fns[6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};

   initial begin
      reset = 1'b1;
      Op    = 6'd0;
      Funct = 6'd0;
      Zero  = 1'b1;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         check_reset_outputs("reset");
      end
      @(posedge clk);
      #1 reset = 1'b0;

      run_instr(6'b100011, 6'b000000);
      run_instr(6'b000000, 6'b100010);
      run_instr(6'b000100, 6'b000000);
      run_instr(6'b101011, 6'b000000);
      run_instr(6'b000010, 6'b000000);
      run_instr(6'b111111, 6'b000000);

      // Abort a lw while it sits in MEMRD.
      Op = 6'b100011;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      check_val("midlw.State", State, 4'd3);
      reset = 1'b1;
      #1;
      check_reset_outputs("midlw");
      repeat (2) begin
         @(negedge clk);
         check_reset_outputs("midlw_hold");
      end
      @(posedge clk);
      #1 reset = 1'b0;

      for (int i = 0; i < 60; i++)
         run_instr(($urandom_range(3, 0) == 0) ? 6'($urandom) : ops[$urandom_range(7, 0)],
                   ($urandom_range(3, 0) == 0) ? 6'($urandom) : fns[$urandom_range(5, 0)]);

      @(negedge clk);
      check_val("final.State", State, 4'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control unit for the multicycle MIPS datapath. A Moore state machine sequences each instruction through fetch, decode, execute, memory and writeback. It drives the datapath mux selects, the memory/IR/PC write enables and the register-file write enable `RegWrite` (wired to the register file's `WE3`). A combinational ALU decoder inside the block produces `ALUControl`.

## Interface
- No parameters; opcode, funct and state codes are package constants.
- `clk` in 1: clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high; forces state FETCH.
- `Op` in 6: `Instr[31:26]` from instruction register.
- `Funct` in 6: `Instr[5:0]` from instruction register.
- `Zero` in 1: ALU zero flag.
- `IorD` out 1: memory address select (0 PC, 1 ALUOut).
- `MemWrite` out 1: data memory write enable.
- `IRWrite` out 1: instruction register load.
- `RegDst` out 1: write-register select (0 rt, 1 rd).
- `MemtoReg` out 1: write-data select (0 ALUOut, 1 Data).
- `RegWrite` out 1: register file write enable (`WE3`).
- `ALUSrcA` out 1: ALU A select (0 PC, 1 A).
- `ALUSrcB` out 2: ALU B select (00 B, 01 const 4, 10 SignImm, 11 SignImm<<2).
- `ALUControl` out 3: ALU op.
- `PCSrc` out 2: next-PC select (00 ALUResult, 01 ALUOut, 10 jump target).
- `PCEn` out 1: PC load = `PCWrite | (Branch & Zero)`.
- `State` out 4: current state code, for debug and bench only.

## Operation
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BEQ 8, ADDIEX 9, ADDIWB 10, JUMP 11.
- Transitions:
  - FETCH→DECODE.
  - DECODE→MEMADR for lw 100011 or sw 101011; EXEC for R-type 000000; BEQ for 000100; ADDIEX for addi 001000; JUMP for j 000010.
  - DECODE→FETCH for any other opcode. The instruction is treated as a NOP: no writes.
  - MEMADR→MEMRD for lw, MEMWR for sw.
  - MEMRD→MEMWB. EXEC→ALUWB. ADDIEX→ADDIWB.
  - MEMWB, MEMWR, ALUWB, ADDIWB, BEQ and JUMP all go to FETCH.
  - Codes 12–15 go to FETCH, with every output 0.
- Outputs per state. Any signal not listed is 0; internal `ALUOp` 00 unless listed.
  - FETCH: ALUSrcB=01, IRWrite, PCWrite.
  - DECODE: ALUSrcB=11.
  - MEMADR: ALUSrcA, ALUSrcB=10.
  - MEMRD: IorD.
  - MEMWB: MemtoReg, RegWrite.
  - MEMWR: IorD, MemWrite.
  - EXEC: ALUSrcA, ALUOp=10.
  - ALUWB: RegDst, RegWrite.
  - BEQ: ALUSrcA, ALUOp=01, PCSrc=01, Branch.
  - ADDIEX: ALUSrcA, ALUSrcB=10.
  - ADDIWB: RegWrite.
  - JUMP: PCSrc=10, PCWrite.
- ALU decoder:
  - ALUOp 00 → 010 (add); 01 → 110 (sub); 10 → decode `Funct`; 11 → 010.
  - Funct decode: 100000 → 010; 100010 → 110; 100100 → 000; 100101 → 001; 101010 → 111; any other → 010.

## Timing
- While `reset`=1, outputs are fixed at: State=0, IorD/RegDst/MemtoReg/ALUSrcA=0, ALUSrcB=01, PCSrc=00, ALUControl=010, and `IRWrite`, `PCEn`, `MemWrite`, `RegWrite` all forced 0.
- The first FETCH cycle is the first rising edge after `reset` deasserts.
- Reset asserted mid-instruction returns the block to FETCH immediately, asynchronously. No write enable may glitch high during reset.
- Outputs are combinational from the state register (Moore), except `PCEn`, which also depends on `Zero` in BEQ.
- `Op` and `Funct` are sampled only in DECODE and MEMADR (next-state) and in EXEC (`ALUControl`). The IR is loaded at the end of FETCH.
- Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown op 2.
- `RegWrite` is high for exactly one cycle per writing instruction. The register file captures on the rising edge that ends that cycle.

## Structure
- Shared package `mips_pkg` holds:
  - state-code localparams;
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
  - funct constants;
  - ALUControl codes.
- Sub-module `alu_decoder` (inputs `ALUOp`, `Funct`; output `ALUControl`), instantiated once.
- The FSM (state register, next-state logic, output decode) lives in the top module.

## Test plan
- Reset held 3 cycles, then released → State=0 during reset with all write enables 0; State=1 after the first post-reset edge.
- lw (Op=100011) → states 0,1,2,3,4,0. RegWrite=1 only in state 4, with MemtoReg=1 and RegDst=0.
- R-type sub (Op=000000, Funct=100010) → states 0,1,6,7,0. ALUControl=110 in state 6. RegWrite=1 with RegDst=1 in state 7.
- beq with Zero=1, then with Zero=0 → states 0,1,8,0 both times. PCEn=1 in state 8 only when Zero=1. PCSrc=01 in state 8.
- sw (101011) and j (000010) → sw visits 0,1,2,5, with MemWrite=1 and IorD=1 in state 5. j visits 0,1,11, with PCEn=1 and PCSrc=10 in state 11.
- Unknown Op=111111 → 0,1,0 with no write enable high in state 1. Reset asserted in state 3 of a lw → State=0 immediately and RegWrite never asserts.
